pc_fetch_unit: RTL and testbench

Program-counter register and instruction-fetch sequencer for the multi-cycle RISC-V core. It consumes the next-PC value produced by the PC-selection logic, holds the architectural PC, and fetches instructions from instruction memory over a request/grant/response handshake. It delivers each instruction to decode over a valid/ready handshake. Misaligned next-PC values raise a sticky fault that stops fetch.

---
 rtl/pc_fetch_unit_if.sv | 35 +++
 rtl/pc_fetch_unit.sv | 118 +++++++++++
 tb/tb_pc_fetch_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Bus between the fetch unit and its neighbours: PC-selection input, the
// instruction-memory request/grant/response channel and the decode
// valid/ready channel. The fetch unit is the master side.
interface pc_fetch_unit_if;
    // PC-selection and control
    logic [31:0] pc_next;
    logic        halt;
    // Instruction-memory channel
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    // Decode channel
    logic        inst_valid;
    logic [31:0] inst;
    logic        inst_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    // Fault reporting
    logic        misalign_fault;
    logic [31:0] fault_addr;

    modport master (
        input  pc_next, halt, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        output imem_req, imem_addr, inst_valid, inst, pc, pc_plus4,
               misalign_fault, fault_addr
    );

    modport slave (
        output pc_next, halt, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        input  imem_req, imem_addr, inst_valid, inst, pc, pc_plus4,
               misalign_fault, fault_addr
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program-counter register and instruction-fetch sequencer. Holds the
// architectural PC, fetches one instruction at a time from instruction
// memory and hands it to decode. The PC only advances on the decode
// handshake; a misaligned next-PC parks the unit in a sticky fault.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    pc_fetch_unit_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic        imem_req_q, imem_req_d;
    logic        inst_valid_q, inst_valid_d;
    logic        fault_q, fault_d;
    logic        handshake;

    assign handshake = inst_valid_q & bus.inst_ready;

    // Next-state and datapath updates; request/valid are derived from the
    // next state so they leave the flops glitch-free.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        fault_addr_d = fault_addr_q;
        fault_d      = fault_q;

        case (state_q)
            S_IDLE: begin
                if (!bus.halt) begin
                    state_d = S_REQ;
                end
            end
            // Request is held until granted; halt does not withdraw it.
            S_REQ: begin
                if (bus.imem_gnt) begin
                    if (bus.imem_rvalid) begin
                        inst_d  = bus.imem_rdata;
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    inst_d  = bus.imem_rdata;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (handshake) begin
                    if (bus.pc_next[1:0] == 2'b00) begin
                        pc_d    = bus.pc_next;
                        state_d = bus.halt ? S_IDLE : S_REQ;
                    end else begin
                        fault_addr_d = bus.pc_next;
                        fault_d      = 1'b1;
                        state_d      = S_FAULT;
                    end
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        imem_req_d   = (state_d == S_REQ);
        inst_valid_d = (state_d == S_HOLD);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= 32'h0;
            fault_addr_q <= 32'h0;
            fault_q      <= 1'b0;
            imem_req_q   <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            fault_addr_q <= fault_addr_d;
            fault_q      <= fault_d;
            imem_req_q   <= imem_req_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign bus.imem_req       = imem_req_q;
    assign bus.imem_addr      = pc_q;
    assign bus.inst_valid     = inst_valid_q;
    assign bus.inst           = inst_q;
    assign bus.pc             = pc_q;
    assign bus.pc_plus4       = pc_q + 32'd4;
    assign bus.misalign_fault = fault_q;
    assign bus.fault_addr     = fault_addr_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit: a memory responder with random grant
// delay and response latency, a random decode consumer, and a
// transaction-level model of the architectural PC and fetch obligations.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pc_fetch_unit_if bus();

    pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Reference model: architectural PC plus what the unit still owes.
    logic [31:0] m_pc, m_fault_addr;
    bit m_fault, m_idle, m_granted, m_have_data;

    // Outputs sampled in the current cycle (seen by the next edge).
    bit          o_req, o_valid;
    logic [31:0] o_addr, o_inst;

    // Memory responder state.
    int          pend;
    logic [31:0] fetch_addr;

    // Stimulus knobs.
    int k_gnt_pct, k_lat_min, k_lat_max, k_ready_pct;
    bit k_halt_en, k_stray, k_misalign;
    logic [31:0] misalign_val;
    int hs_count;

    task automatic model_reset();
        m_pc        = RESET_PC;
        m_fault     = 1'b0;
        m_fault_addr = 32'h0;
        m_idle      = 1'b1;
        m_granted   = 1'b0;
        m_have_data = 1'b0;
        pend        = 0;
    endtask

    task automatic sample_outputs();
        o_req   = bus.imem_req;
        o_valid = bus.inst_valid;
        o_addr  = bus.imem_addr;
        o_inst  = bus.inst;
    endtask

    // Choose inputs for the coming edge from what the DUT shows now.
    task automatic drive_inputs();
        logic [31:0] r;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
        if (o_req) begin
            if ($urandom_range(99) < k_gnt_pct) begin
                int lat;
                lat = $urandom_range(k_lat_max, k_lat_min);
                bus.imem_gnt = 1'b1;
                fetch_addr   = o_addr;
                if (lat == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mem_word(o_addr);
                end else begin
                    pend = lat;
                end
            end
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_word(fetch_addr);
            end
        end else if (k_stray && $urandom_range(7) == 0) begin
            bus.imem_rvalid = 1'b1;
        end
        bus.inst_ready = ($urandom_range(99) < k_ready_pct);
        if (!k_halt_en)
            bus.halt = 1'b0;
        else if ($urandom_range(19) == 0)
            bus.halt = ~bus.halt;
        if (k_misalign) begin
            bus.pc_next = misalign_val;
        end else begin
            r = $urandom;
            case ($urandom_range(99) / 10)
                0, 1:    begin r[1:0] = 2'b00; bus.pc_next = r; end
                2:       bus.pc_next = 32'hFFFF_FFFC;
                default: bus.pc_next = m_pc + 32'd4;
            endcase
        end
    endtask

    // One clock edge: advance the model from pre-edge outputs and the
    // inputs that were applied, then check every visible output.
    task automatic step();
        bit hs, exp_req, exp_valid;
        @(posedge clk);
        #1;
        hs = o_valid && bus.inst_ready;
        if (!m_fault) begin
            if (m_idle && !bus.halt)
                m_idle = 1'b0;
            if (o_req && bus.imem_gnt) begin
                m_granted = 1'b1;
                if (bus.imem_rvalid)
                    m_have_data = 1'b1;
            end else if (m_granted && !m_have_data && bus.imem_rvalid) begin
                m_have_data = 1'b1;
            end
            if (hs) begin
                hs_count++;
                $display("handshake pc=%08h inst=%08h pc_next=%08h halt=%0b",
                         m_pc, o_inst, bus.pc_next, bus.halt);
                if (bus.pc_next[1:0] == 2'b00) begin
                    m_pc        = bus.pc_next;
                    m_granted   = 1'b0;
                    m_have_data = 1'b0;
                    m_idle      = bus.halt;
                end else begin
                    m_fault      = 1'b1;
                    m_fault_addr = bus.pc_next;
                end
            end
        end
        exp_req   = !m_fault && !m_idle && !m_granted;
        exp_valid = !m_fault && m_have_data;
        check_eq("imem_req", 32'(bus.imem_req), 32'(exp_req));
        check_eq("inst_valid", 32'(bus.inst_valid), 32'(exp_valid));
        check_eq("pc", bus.pc, m_pc);
        check_eq("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
        if (exp_req)
            check_eq("imem_addr", bus.imem_addr, m_pc);
        if (exp_valid)
            check_eq("inst", bus.inst, mem_word(m_pc));
        check_eq("misalign_fault", 32'(bus.misalign_fault), 32'(m_fault));
        check_eq("fault_addr", bus.fault_addr, m_fault_addr);
        sample_outputs();
        drive_inputs();
    endtask

    // Mid-cycle asynchronous reset; optionally a stray response right after.
    task automatic apply_reset(input bit stray);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_imem_req", 32'(bus.imem_req), 32'h0);
        check_eq("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
        check_eq("rst_pc", bus.pc, RESET_PC);
        check_eq("rst_pc_plus4", bus.pc_plus4, RESET_PC + 32'd4);
        check_eq("rst_inst", bus.inst, 32'h0);
        check_eq("rst_misalign", 32'(bus.misalign_fault), 32'h0);
        check_eq("rst_fault_addr", bus.fault_addr, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        sample_outputs();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = stray;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        bus.inst_ready  = 1'b1;
        bus.halt        = 1'b0;
        bus.pc_next     = RESET_PC + 32'd4;
    endtask

    initial begin
        bus.pc_next     = 32'h0;
        bus.halt        = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.inst_ready  = 1'b0;
        k_misalign      = 1'b0;
        misalign_val    = 32'h0;
        repeat (2) @(posedge clk);
        #1;

        // Fixed-latency streams: one instruction every (latency + 2) cycles.
        for (int lat = 0; lat < 3; lat++) begin
            k_gnt_pct = 100; k_lat_min = lat; k_lat_max = lat;
            k_ready_pct = 100; k_halt_en = 1'b0; k_stray = 1'b0;
            apply_reset(1'b0);
            hs_count = 0;
            repeat (1 + 10 * (lat + 2)) step();
            check_eq("throughput", 32'(hs_count), 32'd10);
        end

        // Random rounds with stalls, backpressure, halt, strays and resets.
        for (int round = 0; round < 6; round++) begin
            k_gnt_pct   = 30 + $urandom_range(60);
            k_lat_min   = 0;
            k_lat_max   = $urandom_range(3);
            k_ready_pct = 30 + $urandom_range(70);
            k_halt_en   = (round % 2) == 1;
            k_stray     = 1'b1;
            for (int c = 0; c < 400; c++) begin
                step();
                if ($urandom_range(149) == 0)
                    apply_reset(1'b1);
            end

            // Misaligned redirect: fault must latch and fetch must stop.
            k_misalign   = 1'b1;
            k_halt_en    = 1'b0;
            k_ready_pct  = 100;
            k_gnt_pct    = 100;
            misalign_val = (round == 0) ? 32'h0000_0302 : ($urandom | 32'h1);
            for (int c = 0; c < 200 && !bus.misalign_fault; c++)
                step();
            check_eq("fault_reached", 32'(bus.misalign_fault), 32'h1);
            k_misalign = 1'b0;
            repeat (30) step();
            apply_reset(1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus ever stops advancing time.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, expected finish before 2000000");
        $fatal(1, "timeout");
    end

endmodule
